// File: rtl/temp_sensor_pkg.sv
// temp_sensor_pkg: shared FSM/owner encodings and register defaults for the poll scheduler
package temp_sensor_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  typedef enum logic [1:0] {POLL, HOST_RD, HOST_WR} owner_t;
  localparam logic [7:0] DEF_TEMP_REG = 8'h00;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/temp_sensor_poll_scheduler_poll_tick_gen.sv
// poll_tick_gen: free-running 0..PERIOD-1 counter with a one-cycle tick on wrap
module poll_tick_gen #(
  parameter int unsigned PERIOD = 25_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);
  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  logic [W-1:0] r_cnt;
  assign o_tick = r_cnt == W'(PERIOD - 1);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= o_tick ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/temp_sensor_poll_scheduler.sv
// temp_sensor_poll_scheduler: arbitrates host reads/writes and periodic temperature polls onto one I2C command port
import temp_sensor_pkg::*;
module temp_sensor_poll_scheduler #(
  parameter int unsigned POLL_PERIOD = 25_000_000,
  parameter int unsigned RSP_TIMEOUT = 200_000,
  parameter logic [7:0]  TEMP_REG    = DEF_TEMP_REG
) (
  input  logic        Clock_100MHz,
  input  logic        Clear,
  input  logic        Wr_req,
  input  logic [7:0]  Wr_reg,
  input  logic [15:0] Wr_data,
  input  logic        Wr_len,
  input  logic        Rd_req,
  input  logic [7:0]  Rd_reg,
  output logic        Wr_ack,
  output logic        Rd_ack,
  output logic        Cmd_valid,
  input  logic        Cmd_ready,
  output logic        Cmd_rw,
  output logic [7:0]  Cmd_reg,
  output logic [15:0] Cmd_data,
  output logic        Cmd_len,
  input  logic        Rsp_valid,
  input  logic [15:0] Rsp_data,
  input  logic        Rsp_nack,
  output logic [15:0] Temperature,
  output logic        Temp_valid,
  output logic [15:0] Rd_data,
  output logic        Rd_done,
  output logic        Wr_done,
  output logic        Busy,
  output logic        Error,
  output logic [7:0]  Error_count
);
  localparam int TW = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;
  state_t        r_state;
  owner_t        r_owner;
  logic          r_pend;
  logic [TW-1:0] r_to;
  logic          w_tick, w_idle, w_wr_gnt, w_rd_gnt, w_poll_gnt, w_ok, w_abort;

  poll_tick_gen #(.PERIOD(POLL_PERIOD)) u_tick (
    .i_clk (Clock_100MHz),
    .i_rst (Clear),
    .o_tick(w_tick)
  );

  assign w_idle     = r_state == IDLE;
  assign w_wr_gnt   = w_idle & Wr_req;
  assign w_rd_gnt   = w_idle & ~Wr_req & Rd_req;
  assign w_poll_gnt = w_idle & ~Wr_req & ~Rd_req & r_pend;
  // acks are combinational from IDLE, so mask them while Clear holds everything at zero
  assign Wr_ack     = w_wr_gnt & ~Clear;
  assign Rd_ack     = w_rd_gnt & ~Clear;
  assign Cmd_valid  = r_state == ISSUE;
  assign Busy       = ~w_idle;
  assign w_ok       = Rsp_valid & ~Rsp_nack;
  assign w_abort    = (Rsp_valid & Rsp_nack) | (r_to == TW'(RSP_TIMEOUT - 1));

  always_ff @(posedge Clock_100MHz or posedge Clear)
    if (Clear) begin
      r_state     <= IDLE;
      r_owner     <= POLL;
      r_pend      <= 1'b0;
      r_to        <= '0;
      Cmd_rw      <= 1'b0;
      Cmd_reg     <= '0;
      Cmd_data    <= '0;
      Cmd_len     <= 1'b0;
      Temperature <= '0;
      Temp_valid  <= 1'b0;
      Rd_data     <= '0;
      Rd_done     <= 1'b0;
      Wr_done     <= 1'b0;
      Error       <= 1'b0;
      Error_count <= '0;
    end else begin
      Temp_valid <= 1'b0;
      Rd_done    <= 1'b0;
      Wr_done    <= 1'b0;
      r_pend     <= w_poll_gnt ? 1'b0 : (r_pend | w_tick);
      case (r_state)
        IDLE:
          if (w_wr_gnt | w_rd_gnt | w_poll_gnt) begin
            r_state  <= ISSUE;
            r_owner  <= w_wr_gnt ? HOST_WR : w_rd_gnt ? HOST_RD : POLL;
            Cmd_rw   <= ~w_wr_gnt;
            Cmd_reg  <= w_wr_gnt ? Wr_reg : w_rd_gnt ? Rd_reg : TEMP_REG;
            Cmd_data <= w_wr_gnt ? Wr_data : '0;
            Cmd_len  <= w_wr_gnt ? Wr_len : 1'b1;
          end
        ISSUE:
          if (Cmd_ready) begin
            r_state <= WAIT_RSP;
            r_to    <= '0;
          end
        WAIT_RSP:
          if (w_ok) begin
            r_state    <= IDLE;
            Temp_valid <= r_owner == POLL;
            Rd_done    <= r_owner == HOST_RD;
            Wr_done    <= r_owner == HOST_WR;
            if (r_owner == POLL)    Temperature <= Rsp_data;
            if (r_owner == HOST_RD) Rd_data     <= Rsp_data;
          end else if (w_abort) begin
            r_state     <= IDLE;
            Error       <= 1'b1;
            Error_count <= sat_inc(Error_count);
          end else r_to <= r_to + TW'(1);
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_temp_sensor_poll_scheduler.sv
// tb_temp_sensor_poll_scheduler: scoreboard bench with a small I2C engine/sensor model
module tb_temp_sensor_poll_scheduler;
  localparam logic [7:0] TREG = 8'h48;
  logic clk = 1'b0, Clear;
  logic Wr_req, Wr_len, Rd_req, Cmd_ready, Rsp_valid, Rsp_nack;
  logic [7:0] Wr_reg, Rd_reg;
  logic [15:0] Wr_data, Rsp_data;
  logic Wr_ack, Rd_ack, Cmd_valid, Cmd_rw, Cmd_len, Temp_valid, Rd_done, Wr_done, Busy, Error;
  logic [7:0] Cmd_reg, Error_count;
  logic [15:0] Cmd_data, Temperature, Rd_data;

  temp_sensor_poll_scheduler #(.POLL_PERIOD(100), .RSP_TIMEOUT(50), .TEMP_REG(TREG)) dut (
    .Clock_100MHz(clk), .Clear(Clear),
    .Wr_req(Wr_req), .Wr_reg(Wr_reg), .Wr_data(Wr_data), .Wr_len(Wr_len),
    .Rd_req(Rd_req), .Rd_reg(Rd_reg), .Wr_ack(Wr_ack), .Rd_ack(Rd_ack),
    .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready), .Cmd_rw(Cmd_rw), .Cmd_reg(Cmd_reg),
    .Cmd_data(Cmd_data), .Cmd_len(Cmd_len), .Rsp_valid(Rsp_valid), .Rsp_data(Rsp_data),
    .Rsp_nack(Rsp_nack), .Temperature(Temperature), .Temp_valid(Temp_valid),
    .Rd_data(Rd_data), .Rd_done(Rd_done), .Wr_done(Wr_done), .Busy(Busy),
    .Error(Error), .Error_count(Error_count)
  );

  always #5 clk = ~clk;

  int cyc = 0, errors = 0, checks = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // engine / sensor model state
  logic [15:0] mem [256];
  logic [15:0] temp_val = 16'h0C80;
  logic [7:0] silent_reg = 8'hFF, nack_reg = 8'h05;
  bit mute = 0, nack_en = 0;
  int eng_delay = 5;
  logic [24:0] wexp;

  initial begin
    logic e_rw, e_len;
    logic [7:0] e_reg;
    logic [15:0] e_data;
    foreach (mem[i]) mem[i] = 16'h0;
    Rsp_valid = 0; Rsp_data = 0; Rsp_nack = 0;
    forever begin
      @(negedge clk);
      if (Cmd_valid && Cmd_ready && !Clear) begin
        e_rw = Cmd_rw; e_reg = Cmd_reg; e_data = Cmd_data; e_len = Cmd_len;
        if (e_rw) chk("rd_cmd_len", e_len, 1'b1);
        else begin
          chk("wr_cmd_fields", {e_reg, e_data, e_len}, wexp);
          mem[e_reg] = e_len ? e_data : {8'h00, e_data[7:0]};
        end
        if (!(mute || (e_rw && e_reg == silent_reg))) begin
          repeat (eng_delay) @(posedge clk);
          #1 Rsp_valid = 1;
          Rsp_data = e_rw ? ((e_reg == TREG) ? temp_val : mem[e_reg]) : 16'h0;
          Rsp_nack = e_rw && nack_en && (e_reg == nack_reg);
          @(posedge clk);
          #1 Rsp_valid = 0; Rsp_nack = 0;
        end
      end
    end
  end

  // scoreboard monitor
  logic [15:0] q_rd[$];
  logic [7:0]  q_wr[$];
  logic [15:0] exp_temp = 16'h0C80;
  bit temp_allowed = 1, quiet = 0, prev_ok = 0;
  int n_temp = 0, n_rd = 0, n_wr = 0, prev_tv = 0, tv_cyc = 0, rd_cyc = 0, wr_cyc = 0;

  always @(negedge clk) if (!Clear) begin
    if (Wr_done) begin
      chk("wr_done_expected", q_wr.size() != 0, 1'b1);
      if (q_wr.size() != 0) void'(q_wr.pop_front());
      n_wr++; wr_cyc = cyc;
    end
    if (Rd_done) begin
      chk("rd_done_expected", q_rd.size() != 0, 1'b1);
      if (q_rd.size() != 0) chk("rd_data", Rd_data, q_rd.pop_front());
      n_rd++; rd_cyc = cyc;
    end
    if (Temp_valid) begin
      chk("temp_valid_allowed", temp_allowed, 1'b1);
      chk("temperature", Temperature, exp_temp);
      if (quiet) begin
        if (prev_ok) chk("poll_period", cyc - prev_tv, 100);
        prev_tv = cyc; prev_ok = 1;
      end else prev_ok = 0;
      n_temp++; tv_cyc = cyc;
    end
  end

  task automatic wait_temp(input int tgt, input string name);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin @(negedge clk); ok = n_temp >= tgt; end
    chk(name, ok, 1'b1);
  endtask

  task automatic do_write(input logic [7:0] r, input logic [15:0] d, input logic l);
    bit ok = 0;
    int n0 = n_wr;
    wexp = {r, d, l}; q_wr.push_back(r);
    @(posedge clk); #1 Wr_req = 1; Wr_reg = r; Wr_data = d; Wr_len = l;
    for (int i = 0; i < 1000 && !ok; i++) begin @(negedge clk); ok = Wr_ack; end
    chk("wr_ack", ok, 1'b1);
    @(posedge clk); #1 Wr_req = 0;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin @(negedge clk); ok = n_wr > n0; end
    chk("wr_done_seen", ok, 1'b1);
  endtask

  task automatic do_read(input logic [7:0] r, input logic [15:0] e, input bit good);
    bit ok = 0;
    int n0 = n_rd;
    if (good) q_rd.push_back(e);
    @(posedge clk); #1 Rd_req = 1; Rd_reg = r;
    for (int i = 0; i < 1000 && !ok; i++) begin @(negedge clk); ok = Rd_ack; end
    chk("rd_ack", ok, 1'b1);
    @(posedge clk); #1 Rd_req = 0;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = good ? (n_rd > n0) : !Busy;
    end
    chk(good ? "rd_done_seen" : "rd_abort_idle", ok, 1'b1);
  endtask

  logic [7:0]  wv_reg [3] = '{8'h01, 8'h02, 8'h03};
  logic [15:0] wv_dat [3] = '{16'h1234, 16'h56AB, 16'hBEEF};
  logic        wv_len [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] rv_exp [3] = '{16'h1234, 16'h00AB, 16'hBEEF};

  initial begin
    int a, b, t0, r0, bad, acks, wa, ra;
    bit ok, wa_s, ra_s;
    logic [25:0] snap;
    Clear = 1; Wr_req = 0; Wr_reg = 0; Wr_data = 0; Wr_len = 0;
    Rd_req = 0; Rd_reg = 0; Cmd_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_cmd_valid", Cmd_valid, 1'b0);
    chk("rst_temperature", Temperature, 16'h0);
    chk("rst_error_count", Error_count, 8'h0);
    Clear = 0;

    // periodic polling
    wait_temp(1, "first_poll");
    t0 = n_temp; quiet = 1;
    repeat (450) @(negedge clk);
    quiet = 0;
    chk("polls_in_450", n_temp - t0, 4);
    chk("temp_value", Temperature, 16'h0C80);

    // host writes then read-back
    for (int i = 0; i < 3; i++) do_write(wv_reg[i], wv_dat[i], wv_len[i]);
    for (int i = 0; i < 3; i++) do_read(wv_reg[i], rv_exp[i], 1'b1);

    // nack on host read
    chk("no_error_yet", Error, 1'b0);
    nack_en = 1;
    do_read(8'h05, 16'h0, 1'b0);
    nack_en = 0;
    chk("nack_error", Error, 1'b1);
    chk("nack_error_count", Error_count, 8'd1);
    do_read(8'h01, 16'h1234, 1'b1);

    // timeout latency
    silent_reg = 8'h06;
    @(posedge clk); #1 Rd_req = 1; Rd_reg = 8'h06;
    ok = 0; a = 0; b = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (Rd_ack) begin @(posedge clk); #1 Rd_req = 0; end
      if (Cmd_valid && Cmd_ready && Cmd_reg == 8'h06) begin ok = 1; a = cyc + 1; end
    end
    Rd_req = 0; ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); if (!Busy) begin ok = 1; b = cyc; end end
    chk("timeout_latency", b - a, 50);
    chk("timeout_error_count", Error_count, 8'd2);
    silent_reg = 8'hFF;

    // stalled engine with concurrent write, read and poll
    q_rd.push_back(16'hBEEF);
    @(posedge clk); #1 Rd_req = 1; Rd_reg = 8'h03;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin @(negedge clk); ok = Rd_ack; end
    chk("hold_rd_ack", ok, 1'b1);
    @(posedge clk); #1 Rd_req = 0; Cmd_ready = 0;
    @(negedge clk);
    chk("hold_cmd_valid", Cmd_valid, 1'b1);
    chk("hold_cmd_reg", Cmd_reg, 8'h03);
    snap = {Cmd_rw, Cmd_reg, Cmd_data, Cmd_len};
    wexp = {8'h04, 16'h0077, 1'b1}; q_wr.push_back(8'h04); q_rd.push_back(16'h00AB);
    @(posedge clk); #1 Wr_req = 1; Wr_reg = 8'h04; Wr_data = 16'h0077; Wr_len = 1; Rd_req = 1; Rd_reg = 8'h02;
    bad = 0; acks = 0;
    repeat (110) begin
      @(negedge clk);
      if ({Cmd_valid, Cmd_rw, Cmd_reg, Cmd_data, Cmd_len} !== {1'b1, snap}) bad++;
      if (Wr_ack || Rd_ack) acks++;
    end
    chk("cmd_stable_while_stalled", bad, 0);
    chk("no_ack_while_busy", acks, 0);
    r0 = n_rd; t0 = n_temp;
    @(posedge clk); #1 Cmd_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("accept_first_ready", Cmd_valid, 1'b0);
    chk("busy_after_accept", Busy, 1'b1);
    wa_s = 0; ra_s = 0; wa = 0; ra = 0;
    for (int i = 0; i < 600 && !(ra_s && n_temp > t0 && n_rd >= r0 + 2); i++) begin
      @(negedge clk);
      if (Wr_ack && !wa_s) begin wa_s = 1; wa = cyc; end
      if (Rd_ack && !ra_s) begin ra_s = 1; ra = cyc; end
      @(posedge clk); #1;
      if (wa_s) Wr_req = 0;
      if (ra_s) Rd_req = 0;
    end
    Wr_req = 0; Rd_req = 0;
    chk("wr_ack_before_rd_ack", wa_s && ra_s && (wa < ra), 1'b1);
    chk("rd_ack_not_before_wr_done", ra >= wr_cyc, 1'b1);
    chk("poll_after_rd_done", tv_cyc > rd_cyc, 1'b1);
    chk("pending_poll_kept", (tv_cyc - rd_cyc) <= 12, 1'b1);

    // new temperature value
    t0 = n_temp; temp_val = 16'h0D10; exp_temp = 16'h0D10;
    wait_temp(t0 + 1, "poll_after_change");
    chk("temp_updated", Temperature, 16'h0D10);

    // repeated timeouts saturate the error counter
    temp_allowed = 0; mute = 1;
    ok = 0;
    for (int i = 0; i < 40000 && !ok; i++) begin @(negedge clk); ok = Error_count == 8'hFF; end
    chk("error_count_reaches_255", ok, 1'b1);
    repeat (250) @(negedge clk);
    chk("error_count_saturated", Error_count, 8'hFF);
    chk("temp_kept_on_timeout", Temperature, 16'h0D10);
    mute = 0; temp_allowed = 1;

    // Clear during WAIT_RSP
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin @(negedge clk); ok = !Busy; end
    eng_delay = 20;
    @(posedge clk); #1 Rd_req = 1; Rd_reg = 8'h01;
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (Rd_ack) begin @(posedge clk); #1 Rd_req = 0; end
      ok = Busy && !Cmd_valid && Cmd_reg == 8'h01 && !Rd_req;
    end
    chk("reached_wait_rsp", ok, 1'b1);
    repeat (3) @(negedge clk);
    #2 Clear = 1;
    #1;
    chk("clr_busy", Busy, 1'b0);
    chk("clr_error", Error, 1'b0);
    chk("clr_error_count", Error_count, 8'h0);
    chk("clr_temperature", Temperature, 16'h0);
    chk("clr_rd_data", Rd_data, 16'h0);
    chk("clr_cmd_reg", Cmd_reg, 8'h0);
    repeat (3) @(posedge clk);
    #1 Clear = 0;
    r0 = n_rd;
    repeat (40) @(negedge clk);
    chk("no_strobe_after_clear", n_rd - r0, 0);
    chk("idle_after_clear", Busy, 1'b0);
    eng_delay = 5; t0 = n_temp;
    wait_temp(t0 + 1, "poll_after_clear");
    chk("temp_after_clear", Temperature, 16'h0D10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
